// File: rtl/pc_redirect_unit_if.sv
// Hazard-to-fetch handshake bundle: per-slot stall/flush/redirect requests in,
// fetch PC, pipeline-register controls and hazard counters out.
interface pc_redirect_unit_if #(
   parameter int PC_W  = 32,
   parameter int CNT_W = 16
);
   logic [PC_W-1:0]  resetVector;
   logic             Stall1, Stall2;
   logic             Flush1, Flush2;
   logic             CPCSignal1, CPCSignal2;
   logic [PC_W-1:0]  correctPC1, correctPC2;
   logic [PC_W-1:0]  jumpTarget1, jumpTarget2;
   logic [PC_W-1:0]  predPC;
   logic             predValid;
   logic [PC_W-1:0]  pcF;
   logic             ifIdEn;
   logic             ifIdFlush;
   logic             idExFlush1, idExFlush2;
   logic             redirecting;
   logic [CNT_W-1:0] stallCount;
   logic [CNT_W-1:0] flushCount;
   logic             stallOverrun;

   modport master (
      output resetVector, Stall1, Stall2, Flush1, Flush2,
             CPCSignal1, CPCSignal2, correctPC1, correctPC2,
             jumpTarget1, jumpTarget2, predPC, predValid,
      input  pcF, ifIdEn, ifIdFlush, idExFlush1, idExFlush2,
             redirecting, stallCount, flushCount, stallOverrun
   );

   modport slave (
      input  resetVector, Stall1, Stall2, Flush1, Flush2,
             CPCSignal1, CPCSignal2, correctPC1, correctPC2,
             jumpTarget1, jumpTarget2, predPC, predValid,
      output pcF, ifIdEn, ifIdFlush, idExFlush1, idExFlush2,
             redirecting, stallCount, flushCount, stallOverrun
   );
endinterface

// File: rtl/pc_redirect_unit.sv
// Fetch PC / pipeline-register control for the dual-issue front end.
// Slot 1 is the older instruction; its flush wins and squashes slot 2.
module pc_redirect_unit #(
   parameter int PC_W      = 32,
   parameter int FETCH_INC = 8,
   parameter int CNT_W     = 16,
   parameter int MAX_STALL = 3
) (
   input  logic               clk,
   input  logic               rst,
   pc_redirect_unit_if.slave  bus
);

   localparam int RUN_W = (MAX_STALL < 1) ? 1 : $clog2(MAX_STALL + 1);

   typedef enum logic [1:0] {S_RUN, S_STALL, S_REDIRECT} state_t;

   state_t           r_state, w_state_nxt;
   logic [PC_W-1:0]  r_pc, w_pc_nxt, w_target;
   logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;
   logic [RUN_W-1:0] r_run;
   logic             r_overrun;
   logic             w_flush, w_stall;

   assign w_flush = bus.Flush1 | bus.Flush2;
   // Stalls seen during REDIRECT belong to squashed instructions.
   assign w_stall = (bus.Stall1 | bus.Stall2) & ~w_flush & (r_state != S_REDIRECT);

   always_comb begin
      w_target = bus.CPCSignal2 ? bus.correctPC2 : bus.jumpTarget2;
      if (bus.Flush1)
         w_target = bus.CPCSignal1 ? bus.correctPC1 : bus.jumpTarget1;
   end

   always_comb begin
      w_pc_nxt = r_pc + PC_W'(FETCH_INC);
      if (w_flush)            w_pc_nxt = w_target;
      else if (w_stall)       w_pc_nxt = r_pc;
      else if (bus.predValid) w_pc_nxt = bus.predPC;
   end

   always_comb begin
      w_state_nxt = S_RUN;
      if (w_flush)      w_state_nxt = S_REDIRECT;
      else if (w_stall) w_state_nxt = S_STALL;
   end

   always_comb begin
      bus.ifIdEn     = 1'b1;
      bus.ifIdFlush  = 1'b0;
      bus.idExFlush1 = 1'b0;
      bus.idExFlush2 = 1'b0;
      if (rst) begin
         bus.ifIdEn     = 1'b0;
         bus.ifIdFlush  = 1'b1;
         bus.idExFlush1 = 1'b1;
         bus.idExFlush2 = 1'b1;
      end else if (w_flush) begin
         bus.ifIdFlush  = 1'b1;
         bus.idExFlush1 = 1'b1;
         bus.idExFlush2 = 1'b1;
      end else if (w_stall) begin
         bus.ifIdEn     = 1'b0;
         bus.idExFlush1 = 1'b1;
         bus.idExFlush2 = 1'b1;
      end else if (r_state == S_REDIRECT) begin
         // Drop the pair fetched from the stale path.
         bus.ifIdFlush  = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_RUN;
         r_pc    <= bus.resetVector;
      end else begin
         r_state <= w_state_nxt;
         r_pc    <= w_pc_nxt;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         if (w_stall && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + 1'b1;
         if (w_flush && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + 1'b1;
      end
   end

   // Run counter saturates at MAX_STALL; one more stall cycle is an overrun.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_run     <= '0;
         r_overrun <= 1'b0;
      end else if (w_stall) begin
         if (r_run == RUN_W'(MAX_STALL)) r_overrun <= 1'b1;
         else                            r_run     <= r_run + 1'b1;
      end else begin
         r_run <= '0;
      end
   end

   assign bus.pcF          = r_pc;
   assign bus.redirecting  = (r_state == S_REDIRECT);
   assign bus.stallCount   = r_stall_cnt;
   assign bus.flushCount   = r_flush_cnt;
   assign bus.stallOverrun = r_overrun;

endmodule

// File: doc/pc_redirect_unit.md
Name: pc_redirect_unit

Overview:
Consumer of the dual-issue hazard outputs: turns per-slot stall, flush and correct-PC requests into the fetch PC register, IF/ID and ID/EX pipeline-register controls, and hazard performance counters. It sits between the hazard detection logic and the fetch stage of the superscalar core. Slot 1 is always the older instruction of the issue pair.

Parameters:
PC_W, 32, fetch PC width (byte address)
FETCH_INC, 8, PC increment per issued pair (two 4-byte instructions)
CNT_W, 16, width of the stall and flush counters
MAX_STALL, 3, consecutive stall cycles tolerated before stallOverrun is set

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
resetVector  in  PC_W  PC loaded while rst is asserted
Stall1, Stall2  in  1  load-use stall request per slot
Flush1, Flush2  in  1  flush request per slot
CPCSignal1, CPCSignal2  in  1  misprediction; select the correct-PC address for that slot
correctPC1, correctPC2  in  PC_W  recovery address per slot (used when CPCSignalN=1)
jumpTarget1, jumpTarget2  in  PC_W  redirect address per slot (used when FlushN=1, CPCSignalN=0)
predPC  in  PC_W  predictor next-fetch address
predValid  in  1  predPC is valid
pcF  out  PC_W  registered fetch PC
ifIdEn  out  1  IF/ID register write enable
ifIdFlush  out  1  IF/ID register clear
idExFlush1, idExFlush2  out  1  bubble into ID/EX, per slot
redirecting  out  1  FSM is in REDIRECT
stallCount  out  CNT_W  total cycles stalled
flushCount  out  CNT_W  total redirects taken
stallOverrun  out  1  sticky; stall exceeded MAX_STALL consecutive cycles

Behaviour:
- Reset (async): pcF=resetVector, FSM=RUN, stallCount=0, flushCount=0, stallOverrun=0, internal stall run counter=0. Combinational outputs while rst is high: ifIdEn=0, ifIdFlush=1, idExFlush1=idExFlush2=1.
- FSM states: RUN, STALL, REDIRECT. Encoding is free; redirecting=1 only in REDIRECT.
- Effective requests: flush=Flush1|Flush2; stall=(Stall1|Stall2)&!flush&(state!=REDIRECT). In REDIRECT, stall inputs are ignored because they refer to squashed instructions.
- Redirect priority: Flush1 beats Flush2 because the younger slot is squashed. Target for Flush1 is correctPC1 if CPCSignal1, else jumpTarget1. Otherwise the Flush2 target is chosen the same way from slot 2.
- Next PC priority: flush target > hold (stall) > predPC (predValid) > pcF+FETCH_INC. Addition is modulo 2^PC_W and wraps silently.
- Controls, combinational from inputs and state:
  - On flush: ifIdFlush=1, ifIdEn=1, idExFlush1=1.
  - idExFlush2=1 on any flush. Slot 2 is also squashed by Flush1, and its own Flush2 bubbles it.
  - On stall: ifIdEn=0, ifIdFlush=0, idExFlush1=idExFlush2=1 (the pair stalls together, in order).
  - Otherwise: ifIdEn=1 and all flushes 0.
- Transitions:
  - any state, flush -> REDIRECT.
  - RUN, stall -> STALL; else RUN.
  - STALL, stall -> STALL; else RUN.
  - REDIRECT, no flush -> RUN. Stalls are ignored, so there is no direct REDIRECT->STALL transition.
  - REDIRECT, flush again -> stays REDIRECT, new target taken, flushCount increments again.
- REDIRECT lasts one cycle and also asserts ifIdFlush=1 (the pair fetched from the stale path is dropped). pcF advances normally in REDIRECT.
- Counters:
  - stallCount +1 per cycle with effective stall; flushCount +1 per cycle with flush.
  - Both saturate at all-ones and do not wrap.
- Stall run counter: increments on each effective-stall cycle and clears on any non-stall cycle. When it would exceed MAX_STALL, stallOverrun sets and stays set until rst.
- Latency: a flush in cycle N gives pcF=target after edge N; the first correct-path pair is in IF/ID after edge N+1.

Test Plan:
1. Reset with resetVector=0x400 -> pcF=0x400, all counters 0. Release with no hazards, predValid=0 -> pcF 0x408, 0x410, 0x418 on successive edges; ifIdEn=1.
2. Stall2 high for 1 cycle at pcF=0x410 -> pcF holds 0x410 one cycle, ifIdEn=0, idExFlush1=idExFlush2=1, stallCount=1, state STALL then RUN.
3. Flush1=CPCSignal1=1, correctPC1=0x800, plus Flush2=1 with jumpTarget2=0x900 and Stall1=1 in the same cycle -> pcF=0x800, ifIdFlush=1, both idExFlush=1, stallCount unchanged, flushCount=1, next cycle redirecting=1 with ifIdFlush=1.
4. Flush2 only, CPCSignal2=0, jumpTarget2=0xC00 -> pcF=0xC00, idExFlush1=1, idExFlush2=1. Then Stall1=1 during REDIRECT -> ignored, pcF=0xC08.
5. Stall held 4 consecutive cycles with MAX_STALL=3 -> stallOverrun rises on the 4th stall cycle and stays 1 after stalls end. Assert rst mid-stall -> pcF=resetVector immediately, without a clock edge, and stallOverrun=0.
6. Run 0xFFFF+ stall cycles with CNT_W=16 -> stallCount saturates at 0xFFFF. Set pcF near 0xFFFFFFF8 with no hazards -> pcF wraps to 0x00000000.
